// File: rtl/one_hot_pkg.sv
// ============================================================================
// Module : one_hot_pkg
// Brief  : Shared constants for the one-hot to binary decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package one_hot_pkg;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ZERO  = 2'b01;
  localparam logic [1:0] ERR_MULTI = 2'b10;

  localparam int N_DEF     = 16;
  localparam int CNT_W_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/one_hot_check.sv
// ============================================================================
// Module : one_hot_check
// Brief  : Combinational one-hot classifier: lowest set index, zero, multi.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module one_hot_check #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         zero,
  output logic         multi
);

  // Scan from the top so the lowest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (onehot[i]) begin
        idx = W'(i);
      end
    end
  end

  assign zero  = (onehot == '0);
  assign multi = ((onehot & (onehot - N'(1))) != '0);

endmodule

`default_nettype wire

// File: rtl/one_hot_to_binary_decoder.sv
// ============================================================================
// Module : one_hot_to_binary_decoder
// Brief  : Registered one-hot to binary decoder with valid/ready and error count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module one_hot_to_binary_decoder
  import one_hot_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     bin,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [W-1:0] w_idx;
  logic         w_zero;
  logic         w_multi;
  logic         w_accept;
  logic         w_bad;
  logic [1:0]   w_code;

  one_hot_check #(.N(N)) u_check (
    .onehot (onehot),
    .idx    (w_idx),
    .zero   (w_zero),
    .multi  (w_multi)
  );

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_bad    = w_zero || w_multi;
  assign w_code   = w_zero ? ERR_ZERO : (w_multi ? ERR_MULTI : ERR_OK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bin       <= '0;
      err       <= 1'b0;
      err_code  <= ERR_OK;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      bin       <= w_zero ? '0 : w_idx;
      err       <= w_bad;
      err_code  <= w_code;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A clear coinciding with a bad accept leaves a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= (w_accept && w_bad) ? CNT_W'(1) : '0;
    end else if (w_accept && w_bad && (err_cnt != C_CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
